// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin one-hot arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ_DEFAULT   = 8;
  localparam int unsigned IDX_BIT_DEFAULT = $clog2(N_REQ_DEFAULT);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // First set bit of vec scanning from ptr upward with wrap; one-hot or zero.
  function automatic logic [N_REQ_DEFAULT-1:0] rr_first(
    input logic [N_REQ_DEFAULT-1:0]   vec,
    input logic [IDX_BIT_DEFAULT-1:0] ptr
  );
    logic [N_REQ_DEFAULT-1:0]   res;
    logic                       found;
    logic [IDX_BIT_DEFAULT-1:0] pos;
    res   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ_DEFAULT; k++) begin
      pos = IDX_BIT_DEFAULT'((32'(ptr) + k) % N_REQ_DEFAULT);
      if (!found && vec[pos]) begin
        res[pos] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority select: rotate eligible set down by ptr, take lowest set
// bit, rotate back; also encodes the pick to a binary index.
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEFAULT,
  parameter int unsigned IDX_BIT = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0]   i_elig,
  input  logic [IDX_BIT-1:0] i_ptr,
  output logic [N_REQ-1:0]   o_pick,
  output logic [IDX_BIT-1:0] o_idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [N_REQ-1:0]   w_rot_first;

  assign w_dbl       = {i_elig, i_elig};
  assign w_rot       = N_REQ'(w_dbl >> i_ptr);
  assign w_rot_first = w_rot & (~w_rot + N_REQ'(1));
  assign o_pick      = N_REQ'(({w_rot_first, w_rot_first} << i_ptr) >> N_REQ);

  always_comb begin
    o_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (o_pick[i]) o_idx = o_idx | IDX_BIT'(i);
    end
  end

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant with valid/ready.
// Define ARB_REQ_LATCH_EN to latch request pulses until they are granted.
module rr_onehot_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEFAULT,
  parameter int unsigned IDX_BIT = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt_onehot,
  output logic             gnt_valid,
  input  logic             gnt_ready,
  output logic             busy
);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_BIT-1:0] r_ptr;
  logic [IDX_BIT-1:0] r_gnt_idx;
  logic [IDX_BIT-1:0] w_ptr_nxt;
  logic [IDX_BIT-1:0] w_gnt_idx_nxt;
  logic [IDX_BIT-1:0] w_ptr_inc;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic               w_valid_nxt;
  logic               w_accept;
  logic [N_REQ-1:0]   w_elig;
  logic [N_REQ-1:0]   w_elig_clr;
  logic [N_REQ-1:0]   w_pick_vec;
  logic [IDX_BIT-1:0] w_pick_ptr;
  logic [N_REQ-1:0]   w_pick;
  logic [IDX_BIT-1:0] w_pick_idx;

  assign w_accept  = gnt_valid & gnt_ready;
  assign w_ptr_inc = (r_gnt_idx == IDX_BIT'(N_REQ - 1)) ? '0 : r_gnt_idx + IDX_BIT'(1);

`ifdef ARB_REQ_LATCH_EN
  logic [N_REQ-1:0] r_pending;

  // Set wins over the acceptance clear so a re-raised request is kept.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~(w_accept ? gnt_onehot : '0)) | req;
  end

  assign w_elig     = r_pending | req;
  assign w_elig_clr = w_elig & ~gnt_onehot;
`else
  assign w_elig     = req;
  assign w_elig_clr = req;
`endif

  // After an accept, the next pick starts just past the accepted requester.
  assign w_pick_vec = (r_state == GRANT) ? w_elig_clr : w_elig;
  assign w_pick_ptr = (r_state == GRANT) ? w_ptr_inc  : r_ptr;

  rr_pick #(
    .N_REQ   (N_REQ),
    .IDX_BIT (IDX_BIT)
  ) u_pick (
    .i_elig (w_pick_vec),
    .i_ptr  (w_pick_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt_idx  <= '0;
      gnt_onehot <= '0;
      gnt_valid  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      gnt_onehot <= w_gnt_nxt;
      gnt_valid  <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (|w_elig) w_state_nxt = GRANT;
      GRANT:   if (w_accept && !(|w_elig_clr)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt     = gnt_onehot;
    w_valid_nxt   = gnt_valid;
    w_gnt_idx_nxt = r_gnt_idx;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      IDLE: begin
        if (|w_elig) begin
          w_gnt_nxt     = w_pick;
          w_valid_nxt   = 1'b1;
          w_gnt_idx_nxt = w_pick_idx;
        end
      end
      GRANT: begin
        if (w_accept) begin
          w_ptr_nxt = w_ptr_inc;
          if (|w_elig_clr) begin
            w_gnt_nxt     = w_pick;
            w_valid_nxt   = 1'b1;
            w_gnt_idx_nxt = w_pick_idx;
          end else begin
            w_gnt_nxt     = '0;
            w_valid_nxt   = 1'b0;
            w_gnt_idx_nxt = '0;
          end
        end
      end
      default: begin
        w_gnt_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign busy = gnt_valid | (~rst & (|w_elig));

endmodule
